// File: rtl/mf_window_feeder_if.sv
// ============================================================================
// Module   : mf_window_feeder_if
// Brief    : Sample/coefficient bus between the upstream source and the
//            matched-filter window feeder. decim exists only when
//            MF_WIN_DECIM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mf_window_feeder_if #(
    parameter int TAPS = 20,
    parameter int DW   = 32
);
    logic                   pushin;
    logic signed [DW-1:0]   din;
    logic                   flush;
    logic                   wload;
    logic [4:0]             waddr;
    logic signed [DW-1:0]   wdata;
    logic                   wcommit;
`ifdef MF_WIN_DECIM_EN
    logic [3:0]             decim;
`endif
    logic                   pushout;
    logic [TAPS*DW-1:0]     dout;
    logic [TAPS*DW-1:0]     wout;
    logic                   full;

    modport master (
`ifdef MF_WIN_DECIM_EN
        output decim,
`endif
        output pushin, din, flush, wload, waddr, wdata, wcommit,
        input  pushout, dout, wout, full
    );

    modport slave (
`ifdef MF_WIN_DECIM_EN
        input  decim,
`endif
        input  pushin, din, flush, wload, waddr, wdata, wcommit,
        output pushout, dout, wout, full
    );
endinterface

`default_nettype wire

// File: rtl/mf_window_feeder.sv
// ============================================================================
// Module   : mf_window_feeder
// Brief    : Sliding TAPS-sample window plus double-buffered coefficient bank,
//            feeding the matched-filter MAC stage. Optional output decimation
//            is enabled by defining MF_WIN_DECIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mf_window_feeder #(
    parameter int TAPS = 20,
    parameter int DW   = 32
) (
    input  wire                 clk,
    input  wire                 reset,
    mf_window_feeder_if.slave   bus
);

    localparam int                  c_cw   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [c_cw-1:0]     c_last = c_cw'(TAPS - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_cw-1:0]        r_fill;
    logic [TAPS*DW-1:0]     r_win;
    logic [TAPS*DW-1:0]     r_shadow;
    logic [TAPS*DW-1:0]     r_active;
    logic                   r_pushout;
    logic [TAPS*DW-1:0]     r_dout;
    logic [TAPS*DW-1:0]     r_wout;
    logic                   r_full;
`ifdef MF_WIN_DECIM_EN
    logic [3:0]             r_dcnt;
`endif

    logic [TAPS*DW-1:0]     w_shadow_nxt;
    logic [TAPS*DW-1:0]     w_active_nxt;
    logic [TAPS*DW-1:0]     w_win_nxt;
    logic                   w_run_push;

    // Out-of-range addresses match no k and are therefore dropped silently.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int k = 0; k < TAPS; k++) begin
            if (bus.wload && (bus.waddr == 5'(k))) begin
                w_shadow_nxt[k*DW +: DW] = bus.wdata;
            end
        end
    end

    // Commit sees this cycle's write, and a same-cycle push sees the commit.
    assign w_active_nxt = bus.wcommit ? w_shadow_nxt : r_active;
    assign w_win_nxt    = {r_win[(TAPS-1)*DW-1:0], bus.din};

`ifdef MF_WIN_DECIM_EN
    assign w_run_push = (r_dcnt >= bus.decim);
`else
    assign w_run_push = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FILL;
            r_fill    <= '0;
            r_win     <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pushout <= 1'b0;
            r_dout    <= '0;
            r_wout    <= '0;
            r_full    <= 1'b0;
`ifdef MF_WIN_DECIM_EN
            r_dcnt    <= '0;
`endif
        end else begin
            r_shadow  <= w_shadow_nxt;
            r_active  <= w_active_nxt;
            r_pushout <= 1'b0;

            if (bus.flush) begin
                r_state <= S_FILL;
                r_fill  <= '0;
                r_win   <= '0;
                r_full  <= 1'b0;
`ifdef MF_WIN_DECIM_EN
                r_dcnt  <= '0;
`endif
            end else if (bus.pushin) begin
                r_win <= w_win_nxt;
                case (r_state)
                    S_FILL: begin
                        if (r_fill == c_last) begin
                            r_state   <= S_RUN;
                            r_fill    <= '0;
                            r_full    <= 1'b1;
                            r_pushout <= 1'b1;
                            r_dout    <= w_win_nxt;
                            r_wout    <= w_active_nxt;
`ifdef MF_WIN_DECIM_EN
                            r_dcnt    <= '0;
`endif
                        end else begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_run_push) begin
                            r_pushout <= 1'b1;
                            r_dout    <= w_win_nxt;
                            r_wout    <= w_active_nxt;
                        end
`ifdef MF_WIN_DECIM_EN
                        r_dcnt <= w_run_push ? 4'd0 : r_dcnt + 4'd1;
`endif
                    end
                    default: begin
                        r_state <= S_FILL;
                        r_fill  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.pushout = r_pushout;
    assign bus.dout    = r_dout;
    assign bus.wout    = r_wout;
    assign bus.full    = r_full;

endmodule

`default_nettype wire
